decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 The module SHALL have parameter DEPTH, default 2, output queue entries; legal values are powers of two from 2 to 8.
REQ-003 The module SHALL have parameter STRICT, default 1; when 1, reserved encoding fields are checked for illegality.
REQ-004 Port clk, input, 1, single clock; all state changes on rising edge.
REQ-005 Port rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port flush, input, 1, synchronous queue discard.
REQ-007 Ports in_valid input 1, in_ready output 1, in_inst input 32, in_pc input XLEN: instruction upstream handshake.
REQ-008 Ports out_valid output 1, out_ready input 1: downstream handshake.
REQ-009 Port out_op, output, 40: one-hot op, bit 0..39 = LUI AUIPC JAL JALR BEQ BNE BLT BGE BLTU BGEU LB LH LW LBU LHU SB SH SW ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI ADD SUB SLL SLT SLTU XOR SRL SRA OR AND FENCE ECALL EBREAK.
REQ-010 Port out_fmt, output, 3: format, 0=R 1=I 2=S 3=B 4=U 5=J.
REQ-011 Ports out_imm output XLEN, out_rd/out_rs1/out_rs2 output 5 each, out_pc output XLEN.
REQ-012 Port out_illegal, output, 1: illegal encoding; out_jump, output, 1: JAL or JALR.
REQ-013 Port count, output, $clog2(DEPTH)+1: occupied queue entries.

Function
REQ-014 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-015 Decode SHALL be combinational on in_inst; decoded record SHALL be written into the queue on transfer; out_valid SHALL rise the cycle after the first push into an empty queue (latency 1).
REQ-016 Throughput SHALL be one instruction per cycle when out_ready is held high.
REQ-017 in_ready SHALL equal (count != DEPTH); a pop in the same cycle SHALL NOT raise in_ready while full.
REQ-018 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and preserve FIFO order.
REQ-019 out_valid SHALL equal (count != 0); outputs SHALL show the head entry and remain stable while out_valid && !out_ready.
REQ-020 Read/write pointers SHALL wrap modulo DEPTH.
REQ-021 flush SHALL set count to 0 and out_valid to 0 at the next edge; a push or pop in the flush cycle SHALL be discarded; in_ready SHALL be 1 the cycle after.
REQ-022 Opcode/funct3/funct7 decode SHALL follow RV32I base (RV64I shift rules when XLEN=64); JALR requires funct3=0.
REQ-023 out_imm SHALL be sign-extended to XLEN: I = inst[31:20]; S = {inst[31:25],inst[11:7]}; B = {inst[31],inst[7],inst[30:25],inst[11:8],0}; U = {inst[31:12],12'b0}; J = {inst[31],inst[19:12],inst[20],inst[30:21],0}; R = 0.
REQ-024 Shift immediates SHALL be zero-extended shamt (5 bits if XLEN=32, 6 bits if 64).
REQ-025 out_illegal SHALL be 1 and out_op all-zero for: inst[1:0]!=2'b11; unknown opcode/funct3/funct7; XLEN=32 shift with inst[25]=1.
REQ-026 With STRICT=1, ECALL/EBREAK with rs1 or rd nonzero SHALL be illegal; with STRICT=0 those fields are ignored.
REQ-027 Illegal instructions SHALL be queued and delivered in order, never dropped; out_rd/rs1/rs2/pc SHALL carry raw fields.
REQ-028 out_op SHALL have at most one bit set; exactly one when out_illegal=0.

Reset
REQ-029 rst_n low SHALL immediately clear count and pointers and drive out_valid=0, in_ready=0, out_op=0, out_imm=0, out_illegal=0, out_jump=0, out_fmt=0.
REQ-030 in_ready SHALL become 1 at the first rising edge after rst_n deasserts; reset mid-transfer SHALL discard all queued entries.

Verification
REQ-031 Bench: push 0xFFF00093 (ADDI x1,x0,-1), out_ready=1 -> next cycle out_valid=1, out_op bit18, out_fmt=1, out_imm=0xFFFFFFFF, out_rd=1.
REQ-032 Bench: push 0xFE208EE3 (BEQ x1,x2,-4) -> out_op bit4, out_fmt=3, out_imm=0xFFFFFFFC, rs1=1, rs2=2, out_jump=0.
REQ-033 Bench: DEPTH=2, out_ready=0, in_valid held high for 4 cycles with 3 distinct instructions -> count=2, in_ready=0; then out_ready=1 -> all 3 delivered in order.
REQ-034 Bench: push 0x00000000 -> out_illegal=1, out_op=0, record delivered.
REQ-035 Bench: count=2, assert flush with concurrent push -> next cycle count=0, out_valid=0, pushed item never appears.
REQ-036 Bench: drop rst_n while count=1 mid-cycle -> out_valid=0 before next edge; after release in_ready=1, count=0.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I/RV64I instruction decoder feeding a small in-order output queue.
// Each queued record holds the one-hot op, format, immediate, raw register fields and pc.
module decode_stage #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 2,
  parameter bit STRICT = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_inst,
  input  logic [XLEN-1:0]         in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [39:0]             out_op,
  output logic [2:0]              out_fmt,
  output logic [XLEN-1:0]         out_imm,
  output logic [4:0]              out_rd,
  output logic [4:0]              out_rs1,
  output logic [4:0]              out_rs2,
  output logic [XLEN-1:0]         out_pc,
  output logic                    out_illegal,
  output logic                    out_jump,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW  = $clog2(DEPTH);
  localparam int SHW = (XLEN == 64) ? 6 : 5;
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam int OP_LUI   = 0;
  localparam int OP_AUIPC = 1;
  localparam int OP_JAL   = 2;
  localparam int OP_JALR  = 3;
  localparam int OP_BEQ   = 4;
  localparam int OP_BNE   = 5;
  localparam int OP_BLT   = 6;
  localparam int OP_BGE   = 7;
  localparam int OP_BLTU  = 8;
  localparam int OP_BGEU  = 9;
  localparam int OP_LB    = 10;
  localparam int OP_LH    = 11;
  localparam int OP_LW    = 12;
  localparam int OP_LBU   = 13;
  localparam int OP_LHU   = 14;
  localparam int OP_SB    = 15;
  localparam int OP_SH    = 16;
  localparam int OP_SW    = 17;
  localparam int OP_ADDI  = 18;
  localparam int OP_SLTI  = 19;
  localparam int OP_SLTIU = 20;
  localparam int OP_XORI  = 21;
  localparam int OP_ORI   = 22;
  localparam int OP_ANDI  = 23;
  localparam int OP_SLLI  = 24;
  localparam int OP_SRLI  = 25;
  localparam int OP_SRAI  = 26;
  localparam int OP_ADD   = 27;
  localparam int OP_SUB   = 28;
  localparam int OP_SLL   = 29;
  localparam int OP_SLT   = 30;
  localparam int OP_SLTU  = 31;
  localparam int OP_XOR   = 32;
  localparam int OP_SRL   = 33;
  localparam int OP_SRA   = 34;
  localparam int OP_OR    = 35;
  localparam int OP_AND   = 36;
  localparam int OP_FENCE = 37;
  localparam int OP_ECALL = 38;
  localparam int OP_EBRK  = 39;

  typedef struct packed {
    logic [39:0]     op;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] pc;
    logic            illegal;
    logic            jump;
  } rec_t;

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [4:0]      f_rd;
  logic [4:0]      f_rs1;
  logic [4:0]      f_rs2;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_sh;
  logic            sh_ok_l;
  logic            sh_ok_a;

  logic [39:0]     dec_op;
  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;
  rec_t            dec_rec;

  assign opcode = in_inst[6:0];
  assign f3     = in_inst[14:12];
  assign f7     = in_inst[31:25];
  assign f_rd   = in_inst[11:7];
  assign f_rs1  = in_inst[19:15];
  assign f_rs2  = in_inst[24:20];

  assign imm_i  = XLEN'($signed(in_inst[31:20]));
  assign imm_s  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
  assign imm_sh = XLEN'(in_inst[SHW+19:20]);

  // RV64 shifts borrow inst[25] as shamt[5]; on RV32 that bit must be zero
  assign sh_ok_l = (XLEN == 64) ? (in_inst[31:26] == 6'b000000) : (in_inst[31:25] == 7'b0000000);
  assign sh_ok_a = (XLEN == 64) ? (in_inst[31:26] == 6'b010000) : (in_inst[31:25] == 7'b0100000);

  always_comb begin
    dec_op  = '0;
    dec_fmt = FMT_R;
    dec_imm = '0;
    dec_ill = 1'b0;
    case (opcode)
      OPC_LUI: begin
        dec_op[OP_LUI] = 1'b1;
        dec_fmt        = FMT_U;
        dec_imm        = imm_u;
      end
      OPC_AUIPC: begin
        dec_op[OP_AUIPC] = 1'b1;
        dec_fmt          = FMT_U;
        dec_imm          = imm_u;
      end
      OPC_JAL: begin
        dec_op[OP_JAL] = 1'b1;
        dec_fmt        = FMT_J;
        dec_imm        = imm_j;
      end
      OPC_JALR: begin
        dec_fmt = FMT_I;
        dec_imm = imm_i;
        if (f3 == 3'b000) dec_op[OP_JALR] = 1'b1;
        else              dec_ill = 1'b1;
      end
      OPC_BRANCH: begin
        dec_fmt = FMT_B;
        dec_imm = imm_b;
        case (f3)
          3'b000:  dec_op[OP_BEQ]  = 1'b1;
          3'b001:  dec_op[OP_BNE]  = 1'b1;
          3'b100:  dec_op[OP_BLT]  = 1'b1;
          3'b101:  dec_op[OP_BGE]  = 1'b1;
          3'b110:  dec_op[OP_BLTU] = 1'b1;
          3'b111:  dec_op[OP_BGEU] = 1'b1;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec_fmt = FMT_I;
        dec_imm = imm_i;
        case (f3)
          3'b000:  dec_op[OP_LB]  = 1'b1;
          3'b001:  dec_op[OP_LH]  = 1'b1;
          3'b010:  dec_op[OP_LW]  = 1'b1;
          3'b100:  dec_op[OP_LBU] = 1'b1;
          3'b101:  dec_op[OP_LHU] = 1'b1;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec_fmt = FMT_S;
        dec_imm = imm_s;
        case (f3)
          3'b000:  dec_op[OP_SB] = 1'b1;
          3'b001:  dec_op[OP_SH] = 1'b1;
          3'b010:  dec_op[OP_SW] = 1'b1;
          default: dec_ill = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec_fmt = FMT_I;
        dec_imm = imm_i;
        case (f3)
          3'b000: dec_op[OP_ADDI]  = 1'b1;
          3'b010: dec_op[OP_SLTI]  = 1'b1;
          3'b011: dec_op[OP_SLTIU] = 1'b1;
          3'b100: dec_op[OP_XORI]  = 1'b1;
          3'b110: dec_op[OP_ORI]   = 1'b1;
          3'b111: dec_op[OP_ANDI]  = 1'b1;
          3'b001: begin
            dec_imm = imm_sh;
            if (sh_ok_l) dec_op[OP_SLLI] = 1'b1;
            else         dec_ill = 1'b1;
          end
          default: begin
            dec_imm = imm_sh;
            if (sh_ok_l)      dec_op[OP_SRLI] = 1'b1;
            else if (sh_ok_a) dec_op[OP_SRAI] = 1'b1;
            else              dec_ill = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        dec_fmt = FMT_R;
        case ({f7, f3})
          {7'b0000000, 3'b000}: dec_op[OP_ADD]  = 1'b1;
          {7'b0100000, 3'b000}: dec_op[OP_SUB]  = 1'b1;
          {7'b0000000, 3'b001}: dec_op[OP_SLL]  = 1'b1;
          {7'b0000000, 3'b010}: dec_op[OP_SLT]  = 1'b1;
          {7'b0000000, 3'b011}: dec_op[OP_SLTU] = 1'b1;
          {7'b0000000, 3'b100}: dec_op[OP_XOR]  = 1'b1;
          {7'b0000000, 3'b101}: dec_op[OP_SRL]  = 1'b1;
          {7'b0100000, 3'b101}: dec_op[OP_SRA]  = 1'b1;
          {7'b0000000, 3'b110}: dec_op[OP_OR]   = 1'b1;
          {7'b0000000, 3'b111}: dec_op[OP_AND]  = 1'b1;
          default:              dec_ill = 1'b1;
        endcase
      end
      OPC_FENCE: begin
        dec_fmt = FMT_I;
        dec_imm = imm_i;
        if (f3 == 3'b000) dec_op[OP_FENCE] = 1'b1;
        else              dec_ill = 1'b1;
      end
      OPC_SYSTEM: begin
        dec_fmt = FMT_I;
        dec_imm = imm_i;
        if (f3 != 3'b000 || (STRICT && (f_rd != 5'd0 || f_rs1 != 5'd0)))
          dec_ill = 1'b1;
        else if (in_inst[31:20] == 12'h000)
          dec_op[OP_ECALL] = 1'b1;
        else if (in_inst[31:20] == 12'h001)
          dec_op[OP_EBRK] = 1'b1;
        else
          dec_ill = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
    // an illegal record carries only its raw register fields and pc
    if (dec_ill) begin
      dec_op  = '0;
      dec_fmt = FMT_R;
      dec_imm = '0;
    end
  end

  assign dec_rec = '{
    op:      dec_op,
    fmt:     dec_fmt,
    imm:     dec_imm,
    rd:      f_rd,
    rs1:     f_rs1,
    rs2:     f_rs2,
    pc:      in_pc,
    illegal: dec_ill,
    jump:    dec_op[OP_JAL] | dec_op[OP_JALR]
  };

  rec_t          mem [DEPTH];
  rec_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          init_done;
  logic          push;
  logic          pop;

  assign in_ready  = init_done && (count != CNT_FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // init_done holds in_ready low through reset and until the first edge after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + (PW+1)'(1);
          2'b01:   count <= count - (PW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= dec_rec;
  end

  assign head = mem[rd_ptr];

  // gating by out_valid keeps the outputs at zero during reset and while empty
  assign out_op      = out_valid ? head.op      : '0;
  assign out_fmt     = out_valid ? head.fmt     : '0;
  assign out_imm     = out_valid ? head.imm     : '0;
  assign out_rd      = out_valid ? head.rd      : '0;
  assign out_rs1     = out_valid ? head.rs1     : '0;
  assign out_rs2     = out_valid ? head.rs2     : '0;
  assign out_pc      = out_valid ? head.pc      : '0;
  assign out_illegal = out_valid ? head.illegal : 1'b0;
  assign out_jump    = out_valid ? head.jump    : 1'b0;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (XLEN=32, DEPTH=2, STRICT=1) with hand-computed expectations.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] out_op;
  logic [2:0]  out_fmt;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [31:0] out_pc;
  logic        out_illegal;
  logic        out_jump;
  logic [1:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  decode_stage #(.XLEN(32), .DEPTH(2), .STRICT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_fmt(out_fmt), .out_imm(out_imm),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_pc(out_pc),
    .out_illegal(out_illegal), .out_jump(out_jump), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    bit          ill;
    int          bitn;
    logic [2:0]  fmt;
    logic [31:0] imm;
    bit          jump;
    logic [4:0]  rd;
    bit          has_rs;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [31:0] inst, input bit ill, input int bitn,
                         input logic [2:0] fmt, input logic [31:0] imm, input bit jump,
                         input logic [4:0] rd, input bit has_rs,
                         input logic [4:0] rs1, input logic [4:0] rs2);
    vec_t v;
    v.inst = inst; v.ill = ill; v.bitn = bitn; v.fmt = fmt; v.imm = imm;
    v.jump = jump; v.rd = rd; v.has_rs = has_rs; v.rs1 = rs1; v.rs2 = rs2;
    vq.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;

    // reset state
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_count",     64'(count),     64'd0);
    check("rst_out_op",    64'(out_op),    64'd0);
    check("rst_out_imm",   64'(out_imm),   64'd0);
    #9 rst_n = 1'b1;
    #1 check("rel_in_ready_before_edge", 64'(in_ready), 64'd0);
    step();
    check("rel_in_ready_after_edge", 64'(in_ready), 64'd1);

    //          inst          ill bit fmt imm           jmp rd  rs rs1 rs2
    add_vec(32'hFFF00093, 0, 18, 3'd1, 32'hFFFFFFFF, 0, 5'd1,  0, 5'd0, 5'd0);
    add_vec(32'hFE208EE3, 0,  4, 3'd3, 32'hFFFFFFFC, 0, 5'd29, 1, 5'd1, 5'd2);
    add_vec(32'h123450B7, 0,  0, 3'd4, 32'h12345000, 0, 5'd1,  0, 5'd0, 5'd0);
    add_vec(32'h008000EF, 0,  2, 3'd5, 32'h00000008, 1, 5'd1,  0, 5'd0, 5'd0);
    add_vec(32'h402081B3, 0, 28, 3'd0, 32'h00000000, 0, 5'd3,  1, 5'd1, 5'd2);
    add_vec(32'h4030D093, 0, 26, 3'd1, 32'h00000003, 0, 5'd1,  0, 5'd0, 5'd0);
    add_vec(32'hFE20AC23, 0, 17, 3'd2, 32'hFFFFFFF8, 0, 5'd24, 1, 5'd1, 5'd2);
    add_vec(32'h00008067, 0,  3, 3'd1, 32'h00000000, 1, 5'd0,  0, 5'd0, 5'd0);
    add_vec(32'h00000073, 0, 38, 3'd1, 32'h00000000, 0, 5'd0,  0, 5'd0, 5'd0);
    add_vec(32'h02309093, 1,  0, 3'd0, 32'h00000000, 0, 5'd1,  0, 5'd0, 5'd0);
    add_vec(32'h00009067, 1,  0, 3'd0, 32'h00000000, 0, 5'd0,  0, 5'd0, 5'd0);
    add_vec(32'h000000F3, 1,  0, 3'd0, 32'h00000000, 0, 5'd1,  0, 5'd0, 5'd0);
    add_vec(32'h00000000, 1,  0, 3'd0, 32'h00000000, 0, 5'd0,  0, 5'd0, 5'd0);

    // back-to-back stream with out_ready high: each record is at the head one cycle after its push
    out_ready = 1'b1;
    foreach (vq[i]) begin
      in_valid = 1'b1;
      in_inst  = vq[i].inst;
      in_pc    = 32'h1000 + 32'(i * 4);
      step();
      check($sformatf("v%0d_valid", i),   64'(out_valid),   64'd1);
      check($sformatf("v%0d_in_ready", i), 64'(in_ready),   64'd1);
      check($sformatf("v%0d_illegal", i), 64'(out_illegal), 64'(vq[i].ill));
      check($sformatf("v%0d_op", i), 64'(out_op), vq[i].ill ? 64'd0 : (64'd1 << vq[i].bitn));
      check($sformatf("v%0d_rd", i), 64'(out_rd), 64'(vq[i].rd));
      check($sformatf("v%0d_pc", i), 64'(out_pc), 64'(32'h1000 + 32'(i * 4)));
      if (!vq[i].ill) begin
        check($sformatf("v%0d_fmt", i),  64'(out_fmt),  64'(vq[i].fmt));
        check($sformatf("v%0d_imm", i),  64'(out_imm),  64'(vq[i].imm));
        check($sformatf("v%0d_jump", i), 64'(out_jump), 64'(vq[i].jump));
      end
      if (vq[i].has_rs) begin
        check($sformatf("v%0d_rs1", i), 64'(out_rs1), 64'(vq[i].rs1));
        check($sformatf("v%0d_rs2", i), 64'(out_rs2), 64'(vq[i].rs2));
      end
    end
    in_valid = 1'b0;
    step();
    check("stream_drained", 64'(out_valid), 64'd0);

    // backpressure: three instructions offered over four cycles into a two-entry queue
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h200;
    step();
    in_inst = 32'h00200113; in_pc = 32'h204;
    step();
    in_inst = 32'h00300193; in_pc = 32'h208;
    step();
    step();
    check("bp_count_full",  64'(count),     64'd2);
    check("bp_in_ready",    64'(in_ready),  64'd0);
    check("bp_head_pc_a",   64'(out_pc),    64'h200);
    check("bp_head_imm_a",  64'(out_imm),   64'd1);
    out_ready = 1'b1;
    #1 check("bp_pop_no_ready", 64'(in_ready), 64'd0);
    step();
    check("bp_count_after_pop", 64'(count),  64'd1);
    check("bp_head_pc_b",  64'(out_pc),  64'h204);
    check("bp_head_imm_b", 64'(out_imm), 64'd2);
    step();
    in_valid = 1'b0;
    check("bp_head_pc_c",  64'(out_pc),  64'h208);
    check("bp_head_rd_c",  64'(out_rd),  64'd3);
    check("bp_count_c",    64'(count),   64'd1);
    step();
    check("bp_drained", 64'(out_valid), 64'd0);

    // flush with a concurrent push while full
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h280;
    step();
    in_pc = 32'h284;
    step();
    check("fl_count_full", 64'(count), 64'd2);
    in_pc = 32'h300;
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_count",     64'(count),     64'd0);
    check("fl_out_valid", 64'(out_valid), 64'd0);
    check("fl_in_ready",  64'(in_ready),  64'd1);
    out_ready = 1'b1;
    step();
    check("fl_no_ghost_1", 64'(out_valid), 64'd0);
    step();
    check("fl_no_ghost_2", 64'(out_valid), 64'd0);

    // reset dropped mid-cycle with one entry queued
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00000073; in_pc = 32'h400;
    step();
    in_valid = 1'b0;
    check("mr_count_before", 64'(count), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check("mr_out_valid", 64'(out_valid), 64'd0);
    check("mr_in_ready",  64'(in_ready),  64'd0);
    check("mr_count",     64'(count),     64'd0);
    check("mr_out_op",    64'(out_op),    64'd0);
    #2 rst_n = 1'b1;
    #1 check("mr_in_ready_pre_edge", 64'(in_ready), 64'd0);
    step();
    check("mr_in_ready_post", 64'(in_ready),  64'd1);
    check("mr_count_post",    64'(count),     64'd0);
    check("mr_valid_post",    64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
